// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared store encodings, lane geometry helpers and FSM states
package store_buffer_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } sb_state_e;

    function automatic int sb_nb(input int xlen);
        return xlen / 8;
    endfunction

    function automatic int sb_lg_nb(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    // SD only exists on 64-bit datapaths; any 1xx encoding is reserved.
    function automatic logic sb_f3_legal(input logic [2:0] f3, input int xlen);
        return !f3[2] && !(f3 == F3_SD && xlen != 64);
    endfunction

endpackage

// File: rtl/store_buffer_lane_align.sv
// rtl/store_buffer_lane_align.sv - store_lane_align: byte mask, lane data and split flag over a two-word window
module store_lane_align
    import store_buffer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [1:0]                size_log2,
    input  logic [XLEN-1:0]           data,
    output logic [2*(XLEN/8)-1:0]     mask,
    output logic [2*XLEN-1:0]         wdata,
    output logic                      split
);

    localparam int NB = sb_nb(XLEN);

    logic [2*NB-1:0]   size_ones;
    logic [2*XLEN-1:0] wide;

    always_comb begin
        size_ones = '0;
        for (int i = 0; i < 2*NB; i++) begin
            size_ones[i] = (i < (1 << size_log2));
        end
        mask = size_ones << off;
        wide = {{XLEN{1'b0}}, data} << {off, 3'b000};
        // Bytes of rs2 above the store size must not leak into enabled-off lanes.
        wdata = '0;
        for (int b = 0; b < 2*NB; b++) begin
            wdata[8*b +: 8] = mask[b] ? wide[8*b +: 8] : 8'h00;
        end
        split = |mask[2*NB-1:NB];
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO with lane alignment at enqueue and a two-beat write FSM
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               st_valid,
    output logic                               st_ready,
    input  logic [ADDR_W-1:0]                  st_addr,
    input  logic [XLEN-1:0]                    st_data,
    input  logic [2:0]                         st_funct3,
    output logic                               st_err,
    output logic                               mem_valid,
    input  logic                               mem_ready,
    output logic [ADDR_W-$clog2(XLEN/8)-1:0]   mem_addr,
    output logic [XLEN/8-1:0]                  mem_we,
    output logic [XLEN-1:0]                    mem_wdata,
    output logic                               busy
);

    localparam int NB    = sb_nb(XLEN);
    localparam int LG    = sb_lg_nb(XLEN);
    localparam int WA_W  = ADDR_W - LG;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_state_e          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               st_err_q, st_err_d;

    logic [WA_W-1:0]    addr_mem_q  [DEPTH];
    logic [WA_W-1:0]    addr_mem_d  [DEPTH];
    logic [2*NB-1:0]    mask_mem_q  [DEPTH];
    logic [2*NB-1:0]    mask_mem_d  [DEPTH];
    logic [2*XLEN-1:0]  data_mem_q  [DEPTH];
    logic [2*XLEN-1:0]  data_mem_d  [DEPTH];
    logic               split_mem_q [DEPTH];
    logic               split_mem_d [DEPTH];

    logic [2*NB-1:0]    in_mask;
    logic [2*XLEN-1:0]  in_wdata;
    logic               in_split;

    logic               accept;
    logic               push;
    logic               pop;
    logic               head_split;
    logic [WA_W-1:0]    head_addr;
    logic [2*NB-1:0]    head_mask;
    logic [2*XLEN-1:0]  head_data;

    store_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .off       (st_addr[LG-1:0]),
        .size_log2 (st_funct3[1:0]),
        .data      (st_data),
        .mask      (in_mask),
        .wdata     (in_wdata),
        .split     (in_split)
    );

    // Fullness is judged on the registered count so a same-cycle pop never frees the slot early.
    assign st_ready  = !rst && (count_q != CNT_W'(DEPTH));
    assign accept    = st_valid && st_ready;
    assign push      = accept && sb_f3_legal(st_funct3, XLEN);
    assign st_err    = st_err_q;
    assign mem_valid = (state_q != ST_IDLE);
    assign busy      = (count_q != '0) || mem_valid;

    assign head_split = split_mem_q[rd_ptr_q];
    assign head_addr  = addr_mem_q[rd_ptr_q];
    assign head_mask  = mask_mem_q[rd_ptr_q];
    assign head_data  = data_mem_q[rd_ptr_q];

    assign pop = mem_valid && mem_ready && ((state_q == ST_BEAT1) || !head_split);

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        st_err_d = accept && !sb_f3_legal(st_funct3, XLEN);
        addr_mem_d  = addr_mem_q;
        mask_mem_d  = mask_mem_q;
        data_mem_d  = data_mem_q;
        split_mem_d = split_mem_q;

        if (push) begin
            addr_mem_d[wr_ptr_q]  = st_addr[ADDR_W-1:LG];
            mask_mem_d[wr_ptr_q]  = in_mask;
            data_mem_d[wr_ptr_q]  = in_wdata;
            split_mem_d[wr_ptr_q] = in_split;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_d + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_d - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_d != '0) begin
                    state_d = ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                if (mem_ready) begin
                    if (head_split) begin
                        state_d = ST_BEAT1;
                    end else begin
                        state_d = (count_d != '0) ? ST_BEAT0 : ST_IDLE;
                    end
                end
            end
            ST_BEAT1: begin
                if (mem_ready) begin
                    state_d = (count_d != '0) ? ST_BEAT0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced to zero when no beat is presented; the +1 on the beat-1 address wraps naturally.
    always_comb begin
        mem_addr  = '0;
        mem_we    = '0;
        mem_wdata = '0;
        if (state_q == ST_BEAT0) begin
            mem_addr  = head_addr;
            mem_we    = head_mask[NB-1:0];
            mem_wdata = head_data[XLEN-1:0];
        end else if (state_q == ST_BEAT1) begin
            mem_addr  = head_addr + WA_W'(1);
            mem_we    = head_mask[2*NB-1:NB];
            mem_wdata = head_data[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            st_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            st_err_q <= st_err_d;
        end
        addr_mem_q  <= addr_mem_d;
        mask_mem_q  <= mask_mem_d;
        data_mem_q  <= data_mem_d;
        split_mem_q <= split_mem_d;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
Parametrised, registered successor to the combinational store-alignment unit. Accepts stores from the MEM stage over a valid/ready handshake and queues them in a small FIFO. Drives byte-enabled word writes to the data-memory write port. Adds XLEN generalisation (32/64, SD support), misaligned stores split into two word beats, and back-pressure from memory.

Parameters:
XLEN, 32, data/word width in bits; legal values 32 or 64.
DEPTH, 2, FIFO entries; power of two, at least 2.
ADDR_W, 32, byte-address width of st_addr.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
st_valid  in  1  store request valid
st_ready  out  1  buffer can accept a request
st_addr  in  ADDR_W  byte address
st_data  in  XLEN  rs2 data, right-aligned
st_funct3  in  3  store size: 000 SB, 001 SH, 010 SW, 011 SD (XLEN=64 only)
st_err  out  1  one-cycle pulse: illegal funct3 rejected
mem_valid  out  1  write beat valid
mem_ready  in  1  memory accepts beat
mem_addr  out  ADDR_W-log2(XLEN/8)  word address
mem_we  out  XLEN/8  byte write enables
mem_wdata  out  XLEN  lane-aligned write data
busy  out  1  FIFO non-empty or beat in flight

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: st_ready=0 during the rst cycle and 1 after; all other outputs 0; FIFO emptied; FSM set to IDLE.
- Reset mid-operation: queued and in-flight stores are discarded. mem_valid drops the cycle after rst is sampled.
- Enqueue: happens on st_valid & st_ready.
  - st_ready = (count != DEPTH).
  - Same-cycle pop does not free a slot for that cycle's push.
- Illegal funct3 (1xx, or 011 when XLEN=32):
  - The request is still handshaken but not enqueued.
  - st_err=1 the following cycle only.
- Entry contents: word address, byte offset off = st_addr[log2(NB)-1:0] (NB = XLEN/8), size = 1<<funct3[1:0], data.
- Lane formation at enqueue, using 2*NB-bit arithmetic:
  - mask = ((1<<size)-1) << off.
  - wide data = zero-extended st_data << 8*off, over 2*XLEN bits.
  - Beat 0 uses the low halves of mask and data. Beat 1 uses the high halves at word address + 1.
  - split = |mask[2*NB-1:NB].
  - Unused lanes of mem_wdata are 0.
- Output FSM:
  - IDLE: if FIFO non-empty, go to BEAT0 (head drives outputs).
  - BEAT0: mem_valid=1. On mem_ready: if split, go to BEAT1; else pop the entry and go to BEAT0 if another entry remains, otherwise IDLE.
  - BEAT1: mem_valid=1 with the high half. On mem_ready: pop, then go to BEAT0 or IDLE as above.
- Timing:
  - Minimum latency is 1 cycle: a store accepted in cycle N presents mem_valid in cycle N+1.
  - Back-to-back aligned stores sustain 1 beat per cycle while mem_ready=1.
- Output stability: mem_addr, mem_we and mem_wdata stay stable while mem_valid & !mem_ready. mem_valid never deasserts without a handshake, except on rst.
- Word-address wrap: the BEAT1 address on the last word wraps modulo 2^(ADDR_W-log2 NB).
- busy = (count != 0) | mem_valid.

Decomposition:
- Shared package: store funct3 encodings (SB/SH/SW/SD); NB and log2 NB derivation; FSM state encoding (IDLE, BEAT0, BEAT1).
- One sub-module: store_lane_align. It is the combinational mask/data/split generator, parametrised by XLEN, and is instantiated at the FIFO input.
- The FIFO and FSM stay in store_buffer.

Test Plan:
1. XLEN=32. SB at addr 0x1003, data 0xA5, mem_ready=1 -> next cycle: mem_addr=0x400, mem_we=1000, mem_wdata=0xA5000000, single beat.
2. XLEN=32. SW at 0x1006, data 0x11223344 -> beat0: addr 0x401, we=1100, wdata=0x33440000; beat1: addr 0x402, we=0011, wdata=0x00001122.
3. Hold mem_ready=0 and push 3 stores with DEPTH=2 -> st_ready=0 after 2 accepts; outputs stable. Release mem_ready -> drained in order, then busy=0.
4. XLEN=32, funct3=011 -> st_err pulses for 1 cycle; nothing reaches memory. XLEN=64, SD at 0x0 -> we=0xFF, full data, single beat.
5. Assert rst during BEAT1 of a split store with 1 entry queued -> mem_valid=0 the next cycle, busy=0, no further beats.
6. Continuous aligned SH stream with mem_ready=1 -> one beat per cycle, no bubbles, correct we=0011/1100 per offset.
